// File: rtl/spi_slave_engine_if.sv
// spi_slave_engine_if: SPI pad pins plus word-level handshake between the engine and the register/FIFO layer.
interface spi_slave_engine_if #(parameter int DATA_W = 8);
  logic [1:0]        mode;
  logic              cs;
  logic              sclk;
  logic              mosi;
  logic              miso;
  logic [DATA_W-1:0] tx_data;
  logic              tx_load;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              shift;
  logic              sample;
  logic              busy;
  logic              frame_err;
  logic              mode_err;
  modport slave (
    input  mode, cs, sclk, mosi, tx_data,
    output miso, tx_load, rx_data, rx_valid, shift, sample, busy, frame_err, mode_err
  );
  modport master (
    output mode, cs, sclk, mosi, tx_data,
    input  miso, tx_load, rx_data, rx_valid, shift, sample, busy, frame_err, mode_err
  );
endinterface

// File: rtl/spi_slave_engine.sv
// spi_slave_engine: four-mode SPI slave; synchronises pad inputs, assembles rx words, drives miso from a tx shift register.
module spi_slave_engine #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter bit MSB_FIRST   = 1'b1
) (
  input logic clk,
  input logic reset_n,
  spi_slave_engine_if.slave bus
);
  localparam int CW = $clog2(DATA_W);
  typedef enum logic [1:0] {IDLE, ACTIVE, HOLD} state_t;
  state_t state, state_nx;
  logic [SYNC_STAGES-1:0] sclk_s, cs_s, mosi_s;
  logic sclk_d, cs_d, cpol, cpha;
  logic [CW-1:0] bit_cnt;
  logic [DATA_W-1:0] rx_sr, tx_sr, rx_data, rx_nx, tx_nx;
  logic rx_done, rx_valid, tx_load, sample, shift, frame_err, mode_err;
  logic sclk_q, cs_q, mosi_q, cs_fall, cs_rise, lead, trail, act;
  logic samp, shft, last, cnt_zero, start, bad, load, move, busy, miso;

  assign sclk_q = sclk_s[SYNC_STAGES-1];
  assign cs_q   = cs_s[SYNC_STAGES-1];
  assign mosi_q = mosi_s[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sclk_s <= '0;
      cs_s   <= '1;
      mosi_s <= '0;
      sclk_d <= 1'b0;
      cs_d   <= 1'b1;
    end else begin
      sclk_s <= {sclk_s[SYNC_STAGES-2:0], bus.sclk};
      cs_s   <= {cs_s[SYNC_STAGES-2:0], bus.cs};
      mosi_s <= {mosi_s[SYNC_STAGES-2:0], bus.mosi};
      sclk_d <= sclk_q;
      cs_d   <= cs_q;
    end

  // A cs rise masks any sclk edge in the same cycle, so a late edge cannot complete a word.
  always_comb begin
    cs_fall  = cs_d & ~cs_q;
    cs_rise  = ~cs_d & cs_q;
    lead     = (sclk_d == cpol) & (sclk_q != cpol);
    trail    = (sclk_d != cpol) & (sclk_q == cpol);
    act      = (state == ACTIVE) & ~cs_rise;
    samp     = act & (cpha ? trail : lead);
    shft     = act & (cpha ? lead : trail);
    last     = bit_cnt == CW'(DATA_W-1);
    cnt_zero = bit_cnt == '0;
    start    = (state == IDLE) & cs_fall & (sclk_q == bus.mode[1]);
    bad      = (state == IDLE) & cs_fall & (sclk_q != bus.mode[1]);
    load     = start | (shft & ~cpha & cnt_zero) | (samp & cpha & last);
    move     = shft & ~cnt_zero;
    rx_nx    = MSB_FIRST ? {rx_sr[DATA_W-2:0], mosi_q} : {mosi_q, rx_sr[DATA_W-1:1]};
    tx_nx    = MSB_FIRST ? {tx_sr[DATA_W-2:0], 1'b0} : {1'b0, tx_sr[DATA_W-1:1]};
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = cs_fall ? (start ? ACTIVE : HOLD) : IDLE;
      ACTIVE:  state_nx = cs_rise ? IDLE : ACTIVE;
      HOLD:    state_nx = cs_rise ? IDLE : HOLD;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = state == ACTIVE;
    miso = busy & (MSB_FIRST ? tx_sr[DATA_W-1] : tx_sr[0]);
  end

  // Under CPHA=0 a shift at bit_cnt 0 follows a completed word and reloads; under CPHA=1 it is the held first bit.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cpol      <= 1'b0;
      cpha      <= 1'b0;
      bit_cnt   <= '0;
      rx_sr     <= '0;
      tx_sr     <= '0;
      rx_data   <= '0;
      rx_done   <= 1'b0;
      rx_valid  <= 1'b0;
      tx_load   <= 1'b0;
      sample    <= 1'b0;
      shift     <= 1'b0;
      frame_err <= 1'b0;
      mode_err  <= 1'b0;
    end else begin
      if (state == IDLE && cs_fall) {cpol, cpha} <= bus.mode;
      bit_cnt   <= start ? '0 : samp ? (last ? '0 : bit_cnt + CW'(1)) : bit_cnt;
      rx_sr     <= samp ? rx_nx : rx_sr;
      tx_sr     <= load ? bus.tx_data : move ? tx_nx : tx_sr;
      rx_done   <= samp & last;
      rx_valid  <= rx_done;
      rx_data   <= rx_done ? rx_sr : rx_data;
      tx_load   <= load;
      sample    <= samp;
      shift     <= shft;
      frame_err <= (state == ACTIVE) & cs_rise & ~cnt_zero;
      mode_err  <= bad;
    end

  assign bus.miso      = miso;
  assign bus.busy      = busy;
  assign bus.tx_load   = tx_load;
  assign bus.rx_data   = rx_data;
  assign bus.rx_valid  = rx_valid;
  assign bus.sample    = sample;
  assign bus.shift     = shift;
  assign bus.frame_err = frame_err;
  assign bus.mode_err  = mode_err;
endmodule

// File: tb/tb_spi_slave_engine.sv
// tb_spi_slave_engine: directed SPI master exercising MSB-first and LSB-first engines side by side.
module tb_spi_slave_engine;
  localparam int H = 8;
  logic clk = 1'b0, reset_n = 1'b0;
  logic cs = 1'b1, sclk = 1'b0, mosi = 1'b0, cph = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] tx_data = 8'h00, r, r2;
  int total = 0, bad = 0;
  int smp = 0, shf = 0, tld = 0, rxv = 0, fer = 0, mer = 0, lrxv = 0, lfer = 0, lmer = 0, rxn = 0;
  int s_smp, s_shf, s_tld, s_rxv, s_fer, s_mer, s_lrxv, s_lfer, s_lmer, s_rxn;
  logic [7:0] rxw [0:15];
  always #5 clk = ~clk;

  spi_slave_engine_if #(.DATA_W(8)) bm ();
  spi_slave_engine_if #(.DATA_W(8)) bl ();
  assign bm.cs = cs;
  assign bm.sclk = sclk;
  assign bm.mosi = mosi;
  assign bm.mode = mode;
  assign bm.tx_data = tx_data;
  assign bl.cs = cs;
  assign bl.sclk = sclk;
  assign bl.mosi = mosi;
  assign bl.mode = mode;
  assign bl.tx_data = tx_data;

  spi_slave_engine #(.DATA_W(8), .SYNC_STAGES(2), .MSB_FIRST(1'b1)) dut (.clk(clk), .reset_n(reset_n), .bus(bm.slave));
  spi_slave_engine #(.DATA_W(8), .SYNC_STAGES(2), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .reset_n(reset_n), .bus(bl.slave));

  always @(negedge clk) begin
    smp  += int'(bm.sample);
    shf  += int'(bm.shift);
    tld  += int'(bm.tx_load);
    rxv  += int'(bm.rx_valid);
    fer  += int'(bm.frame_err);
    mer  += int'(bm.mode_err);
    lrxv += int'(bl.rx_valid);
    lfer += int'(bl.frame_err);
    lmer += int'(bl.mode_err);
    if (bm.rx_valid) begin
      rxw[rxn % 16] = bm.rx_data;
      rxn++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wt(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic snap();
    s_smp = smp; s_shf = shf; s_tld = tld; s_rxv = rxv; s_fer = fer; s_mer = mer;
    s_lrxv = lrxv; s_lfer = lfer; s_lmer = lmer; s_rxn = rxn;
  endtask

  task automatic begin_frame(input logic [1:0] m);
    mode = m;
    cph = m[0];
    sclk = m[1];
    wt(6);
    cs = 1'b0;
    wt(H);
  endtask

  task automatic end_frame();
    wt(H);
    cs = 1'b1;
    wt(2*H);
  endtask

  task automatic xfer(input logic [7:0] d, input int nb, input bit lsb, output logic [7:0] q);
    int k;
    q = '0;
    for (int i = 0; i < nb; i++) begin
      k = lsb ? i : 7 - i;
      if (!cph) begin
        mosi = d[k];
        wt(H);
        q[k] = lsb ? bl.miso : bm.miso;
        sclk = ~sclk;
        wt(H);
        sclk = ~sclk;
      end else begin
        sclk = ~sclk;
        mosi = d[k];
        wt(H);
        q[k] = lsb ? bl.miso : bm.miso;
        sclk = ~sclk;
        wt(H);
      end
    end
  endtask

  initial begin
    wt(3);
    chk("reset_busy", bm.busy, 0);
    chk("reset_miso", bm.miso, 0);
    chk("reset_rx_data", bm.rx_data, 0);
    chk("reset_rx_valid", bm.rx_valid, 0);
    reset_n = 1'b1;
    wt(3);

    // mode 0, single word
    snap();
    tx_data = 8'h3C;
    begin_frame(2'b00);
    chk("m0_busy", bm.busy, 1);
    chk("m0_first_load", tld - s_tld, 1);
    xfer(8'hA5, 8, 1'b0, r);
    end_frame();
    chk("m0_samples", smp - s_smp, 8);
    chk("m0_shifts", shf - s_shf, 8);
    chk("m0_rx_valid", rxv - s_rxv, 1);
    chk("m0_rx_data", bm.rx_data, 8'hA5);
    chk("m0_miso", r, 8'h3C);
    chk("m0_tx_load", tld - s_tld, 2);
    chk("m0_errs", (fer - s_fer) + (mer - s_mer), 0);
    chk("m0_idle_busy", bm.busy, 0);

    // mode 3, back-to-back words; mode input disturbed mid-frame
    snap();
    tx_data = 8'h81;
    begin_frame(2'b11);
    chk("m3_first_load", tld - s_tld, 1);
    tx_data = 8'h7E;
    mode = 2'b00;
    xfer(8'h12, 8, 1'b0, r);
    xfer(8'h34, 8, 1'b0, r2);
    end_frame();
    chk("m3_rx_valid", rxv - s_rxv, 2);
    chk("m3_word0", rxw[s_rxn % 16], 8'h12);
    chk("m3_word1", rxw[(s_rxn + 1) % 16], 8'h34);
    chk("m3_miso0", r, 8'h81);
    chk("m3_miso1", r2, 8'h7E);
    chk("m3_samples", smp - s_smp, 16);

    // modes 1 and 2, LSB first
    snap();
    tx_data = 8'h3C;
    begin_frame(2'b01);
    xfer(8'hF0, 8, 1'b1, r);
    end_frame();
    chk("m1_lsb_rx", bl.rx_data, 8'hF0);
    chk("m1_lsb_miso", r, 8'h3C);
    chk("m1_lsb_valid", lrxv - s_lrxv, 1);
    chk("m1_msb_view", bm.rx_data, 8'h0F);
    snap();
    tx_data = 8'hA6;
    begin_frame(2'b10);
    xfer(8'h0F, 8, 1'b1, r);
    end_frame();
    chk("m2_lsb_rx", bl.rx_data, 8'h0F);
    chk("m2_lsb_miso", r, 8'hA6);
    chk("m2_lsb_errs", (lfer - s_lfer) + (lmer - s_lmer), 0);

    // partial word then recovery
    snap();
    begin_frame(2'b00);
    xfer(8'h99, 5, 1'b0, r);
    end_frame();
    chk("fe_count", fer - s_fer, 1);
    chk("fe_no_valid", rxv - s_rxv, 0);
    chk("fe_rx_hold", bm.rx_data, 8'hF0);
    snap();
    begin_frame(2'b00);
    xfer(8'hC3, 8, 1'b0, r);
    end_frame();
    chk("fe_next_rx", bm.rx_data, 8'hC3);
    chk("fe_next_clean", fer - s_fer, 0);

    // wrong sclk idle level at cs fall
    snap();
    mode = 2'b10;
    sclk = 1'b0;
    wt(6);
    cs = 1'b0;
    wt(H);
    chk("me_busy", bm.busy, 0);
    repeat (4) begin
      sclk = ~sclk;
      wt(H);
    end
    chk("me_count", mer - s_mer, 1);
    chk("me_no_strobes", (smp - s_smp) + (shf - s_shf), 0);
    chk("me_miso", bm.miso, 0);
    cs = 1'b1;
    wt(2*H);
    snap();
    begin_frame(2'b10);
    xfer(8'h6B, 8, 1'b0, r);
    end_frame();
    chk("me_next_rx", bm.rx_data, 8'h6B);
    chk("me_next_valid", rxv - s_rxv, 1);

    // asynchronous reset mid-frame
    tx_data = 8'h3C;
    begin_frame(2'b01);
    xfer(8'h55, 3, 1'b0, r);
    chk("rst_pre_busy", bm.busy, 1);
    chk("rst_pre_miso", bm.miso, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_busy", bm.busy, 0);
    chk("rst_miso", bm.miso, 0);
    chk("rst_rx_data", bm.rx_data, 0);
    cs = 1'b1;
    sclk = 1'b0;
    wt(4);
    reset_n = 1'b1;
    wt(4);
    snap();
    begin_frame(2'b01);
    xfer(8'h55, 8, 1'b0, r);
    end_frame();
    chk("rst_next_rx", bm.rx_data, 8'h55);
    chk("rst_next_valid", rxv - s_rxv, 1);
    chk("rst_next_miso", r, 8'h3C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
